// File: rtl/alu_bist_ctrl.sv
// Self-test controller for a small combinational ALU: sweeps every (A, B, sel) vector,
// checks alu_out against a built-in reference model and records the first failure.
module alu_bist_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_sel,
    output logic [WIDTH-1:0] fail_got
);

    localparam int unsigned IW = 2 * WIDTH + 3;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [IW-1:0]    idx, idx_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [15:0]      err_next;
    logic [WIDTH-1:0] fail_a_next, fail_b_next, fail_got_next;
    logic [2:0]       fail_sel_next;
    logic             busy_next, done_next, pass_next;
    logic [WIDTH-1:0] expected;

    // Vector index doubles as the driven operands: sel is the fastest-moving field.
    assign alu_sel = idx[2:0];
    assign alu_b   = idx[WIDTH+2:3];
    assign alu_a   = idx[IW-1:WIDTH+3];

    // Reference model, results truncated to WIDTH.
    always_comb begin
        expected = '0;
        case (alu_sel)
            3'd0:    expected = alu_a + alu_b;
            3'd1:    expected = alu_a - alu_b;
            3'd2:    expected = alu_a & alu_b;
            3'd3:    expected = alu_a | alu_b;
            3'd4:    expected = alu_a ^ alu_b;
            3'd5:    expected = ~alu_a;
            3'd6:    expected = {alu_a[WIDTH-2:0], 1'b0};
            default: expected = {1'b0, alu_a[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_sel  <= '0;
            fail_got  <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            cnt       <= cnt_next;
            busy      <= busy_next;
            done      <= done_next;
            pass      <= pass_next;
            err_count <= err_next;
            fail_a    <= fail_a_next;
            fail_b    <= fail_b_next;
            fail_sel  <= fail_sel_next;
            fail_got  <= fail_got_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        cnt_next      = cnt;
        err_next      = err_count;
        fail_a_next   = fail_a;
        fail_b_next   = fail_b;
        fail_sel_next = fail_sel;
        fail_got_next = fail_got;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next    = DRIVE;
                    idx_next      = '0;
                    err_next      = '0;
                    fail_a_next   = '0;
                    fail_b_next   = '0;
                    fail_sel_next = '0;
                    fail_got_next = '0;
                end
            end
            DRIVE: begin
                state_next = WAIT;
                cnt_next   = '0;
            end
            WAIT: begin
                if (cnt == CW'(SETTLE - 1)) state_next = CHECK;
                else                        cnt_next   = cnt + CW'(1);
            end
            CHECK: begin
                if (alu_out != expected) begin
                    if (err_count != 16'hFFFF) err_next = err_count + 16'd1;
                    // Only the first mismatch of a sweep is recorded.
                    if (err_count == 16'd0) begin
                        fail_a_next   = alu_a;
                        fail_b_next   = alu_b;
                        fail_sel_next = alu_sel;
                        fail_got_next = alu_out;
                    end
                end
                if (idx == '1) begin
                    state_next = DONE;
                end else begin
                    state_next = DRIVE;
                    idx_next   = idx + IW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == DRIVE) || (state_next == WAIT) || (state_next == CHECK);
        done_next = (state_next == DONE);
        pass_next = done_next && (err_next == 16'd0);
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: a faultable ALU model answers the controller; each sweep's
// expected summary is queued at start and checked when done rises.
module tb_alu_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [3:0]  alu_a, alu_b, alu_out, fail_a, fail_b, fail_got;
    logic [2:0]  alu_sel, fail_sel;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [1:0]  fault;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alu_bist_ctrl #(.WIDTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_a(fail_a), .fail_b(fail_b), .fail_sel(fail_sel), .fail_got(fail_got)
    );

    function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
        logic [4:0] t;
        case (sel)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; return t[3:0]; end
            3'd1: begin t = {1'b0, a} - {1'b0, b}; return t[3:0]; end
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: begin t = {a, 1'b0}; return t[3:0]; end
            default: return {1'b0, a[3:1]};
        endcase
    endfunction

    // Device under test for the controller: 0 good, 1 bit0 stuck-at-0, 2 sel 6 rotates.
    always_comb begin
        alu_out = ref_alu(alu_a, alu_b, alu_sel);
        if (fault == 2'd1) alu_out[0] = 1'b0;
        if (fault == 2'd2 && alu_sel == 3'd6) alu_out = {alu_a[2:0], alu_a[3]};
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " pass"}, 32'(pass), 0);
        chk({tag, " err"}, 32'(err_count), 0);
        chk({tag, " alu"}, {21'd0, alu_a, alu_b, alu_sel}, 0);
        chk({tag, " fail"}, {17'd0, fail_a, fail_b, fail_sel, fail_got}, 0);
    endtask

    typedef struct {
        logic [1:0]  fault;
        bit          poke_busy;
        int          cycles;
        logic        pass;
        logic [15:0] err;
        logic [3:0]  fa, fb, fgot;
        logic [2:0]  fsel;
    } row_t;

    row_t rows[4];
    row_t sb[$];

    task automatic run_sweep(input row_t r, input string tag);
        row_t e;
        int   cyc;
        fault = r.fault;
        sb.push_back(r);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        // First cycle after start: state cleared and first vector presented.
        chk({tag, " busy@1"}, 32'(busy), 1);
        chk({tag, " done@1"}, 32'(done), 0);
        chk({tag, " clr@1"}, {12'd0, err_count, fail_a, fail_got}, 0);
        chk({tag, " vec0"}, {21'd0, alu_a, alu_b, alu_sel}, 0);
        while (!done && cyc < 8000) begin
            @(posedge clk); #1;
            cyc++;
            if (r.poke_busy) start = (cyc == 100);
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, " done_cycle"}, 32'(cyc), 32'(e.cycles));
        chk({tag, " pass"}, 32'(pass), 32'(e.pass));
        chk({tag, " err"}, 32'(err_count), 32'(e.err));
        chk({tag, " fail_vec"}, {17'd0, fail_a, fail_b, fail_sel, fail_got},
            {17'd0, e.fa, e.fb, e.fsel, e.fgot});
        chk({tag, " busy_end"}, 32'(busy), 0);
        chk({tag, " alu_hold"}, {21'd0, alu_a, alu_b, alu_sel}, 32'h7FF);
        @(posedge clk); #1;
        chk({tag, " done_held"}, 32'(done), 1);
    endtask

    initial begin
        int bit0_ones;
        bit0_ones = 0;
        for (int v = 0; v < 2048; v++) begin
            logic [10:0] iv;
            logic [3:0]  r;
            iv = 11'(v);
            r  = ref_alu(iv[10:7], iv[6:3], iv[2:0]);
            if (r[0]) bit0_ones++;
        end

        rows[0] = '{fault: 2'd0, poke_busy: 1'b0, cycles: 6145, pass: 1'b1, err: 16'd0,
                    fa: 4'h0, fb: 4'h0, fgot: 4'h0, fsel: 3'd0};
        rows[1] = '{fault: 2'd1, poke_busy: 1'b0, cycles: 6145, pass: 1'b0,
                    err: 16'(bit0_ones), fa: 4'h0, fb: 4'h0, fgot: 4'hE, fsel: 3'd5};
        rows[2] = '{fault: 2'd2, poke_busy: 1'b0, cycles: 6145, pass: 1'b0, err: 16'd128,
                    fa: 4'h8, fb: 4'h0, fgot: 4'h1, fsel: 3'd6};
        rows[3] = '{fault: 2'd0, poke_busy: 1'b1, cycles: 6145, pass: 1'b1, err: 16'd0,
                    fa: 4'h0, fb: 4'h0, fgot: 4'h0, fsel: 3'd0};

        fault = 2'd0;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_start", 32'(busy), 0);

        // Rows 2->3 also cover a restart from DONE after a failing sweep.
        for (int i = 0; i < 4; i++) run_sweep(rows[i], $sformatf("row%0d", i));

        // Reset mid-sweep aborts everything on the following cycle.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_all_zero("midrst");

        // Start coinciding with reset: reset wins.
        @(negedge clk);
        start = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        chk("start_vs_reset_busy", 32'(busy), 0);
        @(posedge clk); #1;
        chk("start_vs_reset_idle", 32'(busy), 0);

        run_sweep(rows[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
